// File: rtl/stack_pkg.sv
// Shared stack sizing constants used by the processor top level.
// No logic, so no latency.
// No flow control, so no backpressure.
package stack_pkg;
    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 512;
endpackage

// File: rtl/lifo_ram.sv
// Stack storage: DEPTH x DATA_W, one synchronous write port and one asynchronous read port.
// Latency: a write lands on the clock edge; a read is combinational.
// No backpressure: a write with we high always completes.
module lifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 512,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// LIFO stack with registered top-of-stack; sticky error flags only when LIFO_STACK_ERR_EN is defined.
// Latency: 1 cycle from push/pop to dout/count/empty/full.
// No backpressure: push when full and pop when empty are dropped (flagged when errors are enabled).
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    input  logic              err_clear,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [AW-1:0]     rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              ovf_evt;
    logic              unf_evt;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Push+pop on a non-empty stack replaces the top entry in place.
    always_comb begin
        wr_en   = !reset && push && (pop || !full);
        wr_addr = (push && pop && !empty) ? AW'(count - CNT_W'(1)) : AW'(count);
        rd_addr = AW'(count - CNT_W'(2));
        ovf_evt = push && !pop && full;
        unf_evt = pop && !push && empty;
    end

    lifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (din),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            dout  <= '0;
        end else if (push && pop) begin
            dout <= din;
            if (empty) begin
                count <= CNT_W'(1);
            end
        end else if (push) begin
            if (!full) begin
                count <= count + CNT_W'(1);
                dout  <= din;
            end
        end else if (pop) begin
            // The last entry leaves dout at zero so stale memory is never exposed.
            if (count > CNT_W'(1)) begin
                count <= count - CNT_W'(1);
                dout  <= rd_data;
            end else if (!empty) begin
                count <= '0;
                dout  <= '0;
            end
        end
    end

`ifdef LIFO_STACK_ERR_EN
    // A new error in the same cycle as err_clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= (err_overflow  && !err_clear) || ovf_evt;
            err_underflow <= (err_underflow && !err_clear) || unf_evt;
        end
    end
`else
    logic unused_err;
    assign unused_err    = err_clear ^ ovf_evt ^ unf_evt;
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack (DATA_W=8, DEPTH=4): directed vector table plus random traffic against a queue model.
module tb_lifo_stack;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CW = $clog2(DP + 1);
`ifdef LIFO_STACK_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, push, pop, err_clear;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic [CW-1:0] count;
    logic          empty, full, err_overflow, err_underflow;

    int tests = 0;
    int fails = 0;

    lifo_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .pop           (pop),
        .din           (din),
        .dout          (dout),
        .count         (count),
        .empty         (empty),
        .full          (full),
        .err_clear     (err_clear),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst;
        logic       psh;
        logic       pp;
        logic       clr;
        logic [7:0] d;
        int         cnt;
        logic [7:0] q;
        logic       ovf;
        logic       unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string nm, logic rst, logic psh, logic pp, logic clr,
                                logic [7:0] d, int cnt, logic [7:0] q, logic ovf, logic unf);
        vec_t v;
        v.nm = nm; v.rst = rst; v.psh = psh; v.pp = pp; v.clr = clr; v.d = d;
        v.cnt = cnt; v.q = q; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rst, logic psh, logic pp, logic clr, logic [7:0] d);
        @(negedge clk);
        reset = rst; push = psh; pop = pp; err_clear = clr; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(string nm, int cnt, logic [7:0] q, logic ovf, logic unf);
        chk({nm, ".count"}, 32'(count), 32'(cnt));
        chk({nm, ".dout"},  32'(dout),  32'(q));
        chk({nm, ".empty"}, 32'(empty), 32'(cnt == 0));
        chk({nm, ".full"},  32'(full),  32'(cnt == DP));
        chk({nm, ".ovf"},   32'(err_overflow),  32'(ovf & ERR));
        chk({nm, ".unf"},   32'(err_underflow), 32'(unf & ERR));
    endtask

    // Reference model: the stack as a queue, back = top.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_ovf, m_unf;

    task automatic model_step(logic rst, logic psh, logic pp, logic clr, logic [7:0] d);
        logic oe, ue;
        oe = 1'b0; ue = 1'b0;
        if (rst) begin
            mq.delete(); m_dout = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            if (psh && pp) begin
                if (mq.size() > 0) mq[mq.size()-1] = d;
                else mq.push_back(d);
                m_dout = d;
            end else if (psh) begin
                if (mq.size() < DP) begin mq.push_back(d); m_dout = d; end
                else oe = 1'b1;
            end else if (pp) begin
                if (mq.size() > 0) begin
                    void'(mq.pop_back());
                    m_dout = (mq.size() > 0) ? mq[mq.size()-1] : 8'h00;
                end else ue = 1'b1;
            end
            m_ovf = (m_ovf && !clr) || oe;
            m_unf = (m_unf && !clr) || ue;
        end
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; err_clear = 1'b0; din = '0;

        tbl.push_back(mk("rst",        1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk("push11",     0, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0));
        tbl.push_back(mk("push22",     0, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0));
        tbl.push_back(mk("push33",     0, 1, 0, 0, 8'h33, 3, 8'h33, 0, 0));
        tbl.push_back(mk("push44",     0, 1, 0, 0, 8'h44, 4, 8'h44, 0, 0));
        tbl.push_back(mk("ovf55",      0, 1, 0, 0, 8'h55, 4, 8'h44, 1, 0));
        tbl.push_back(mk("clr_ovf",    0, 0, 0, 1, 8'h00, 4, 8'h44, 0, 0));
        tbl.push_back(mk("pop_33",     0, 0, 1, 0, 8'h00, 3, 8'h33, 0, 0));
        tbl.push_back(mk("pop_22",     0, 0, 1, 0, 8'h00, 2, 8'h22, 0, 0));
        tbl.push_back(mk("pop_11",     0, 0, 1, 0, 8'h00, 1, 8'h11, 0, 0));
        tbl.push_back(mk("pop_00",     0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk("unf",        0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(mk("pp_empty7A", 0, 1, 1, 0, 8'h7A, 1, 8'h7A, 0, 1));
        tbl.push_back(mk("pop_7A",     0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(mk("push01",     0, 1, 0, 0, 8'h01, 1, 8'h01, 0, 1));
        tbl.push_back(mk("push02",     0, 1, 0, 0, 8'h02, 2, 8'h02, 0, 1));
        tbl.push_back(mk("replace09",  0, 1, 1, 0, 8'h09, 2, 8'h09, 0, 1));
        tbl.push_back(mk("pop_01",     0, 0, 1, 0, 8'h00, 1, 8'h01, 0, 1));
        tbl.push_back(mk("clr_unf",    0, 0, 0, 1, 8'h00, 1, 8'h01, 0, 0));
        tbl.push_back(mk("rst_push66", 1, 1, 0, 0, 8'h66, 0, 8'h00, 0, 0));
        tbl.push_back(mk("unf_rst",    0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 1));
        tbl.push_back(mk("rst2",       1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0));
        tbl.push_back(mk("pushA1",     0, 1, 0, 0, 8'hA1, 1, 8'hA1, 0, 0));
        tbl.push_back(mk("pushA2",     0, 1, 0, 0, 8'hA2, 2, 8'hA2, 0, 0));
        tbl.push_back(mk("pushA3",     0, 1, 0, 0, 8'hA3, 3, 8'hA3, 0, 0));
        tbl.push_back(mk("pushA4",     0, 1, 0, 0, 8'hA4, 4, 8'hA4, 0, 0));
        tbl.push_back(mk("ovf_and_clr",0, 1, 0, 1, 8'hB0, 4, 8'hA4, 1, 0));
        tbl.push_back(mk("replace_ful",0, 1, 1, 0, 8'hC5, 4, 8'hC5, 1, 0));
        tbl.push_back(mk("pop_A3",     0, 0, 1, 0, 8'h00, 3, 8'hA3, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].psh, tbl[i].pp, tbl[i].clr, tbl[i].d);
            check_state(tbl[i].nm, tbl[i].cnt, tbl[i].q, tbl[i].ovf, tbl[i].unf);
        end

        // Random traffic; bias alternates between filling and draining phases.
        model_step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 600; n++) begin
            logic       r_rst, r_psh, r_pp, r_clr;
            logic [7:0] r_d;
            int         bias;
            bias  = ((n / 40) % 2 == 0) ? 70 : 30;
            r_rst = ($urandom_range(0, 99) == 0);
            r_psh = ($urandom_range(0, 99) < bias);
            r_pp  = ($urandom_range(0, 99) < (100 - bias));
            r_clr = ($urandom_range(0, 9) == 0);
            r_d   = 8'($urandom);
            drive(r_rst, r_psh, r_pp, r_clr, r_d);
            model_step(r_rst, r_psh, r_pp, r_clr, r_d);
            check_state("rand", mq.size(), m_dout, m_ovf, m_unf);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
